// File: rtl/mem_stage_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting in the MEM stage.
// Loads hit combinationally; misses and stores stall the pipeline while the backing memory is accessed.
module mem_stage_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memreadm,
    input  logic                  memwritem,
    input  logic [2:0]            funct3m,
    input  logic [DATA_WIDTH-1:0] aluresultm,
    input  logic [DATA_WIDTH-1:0] writedatam,
    output logic [DATA_WIDTH-1:0] readdatam,
    output logic                  stallm,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = DATA_WIDTH - SET_BITS - 2;
    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                  state_q, state_d;
    logic [SETS-1:0]         valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q  [SETS];
    logic [DATA_WIDTH-1:0]   data_q [SETS];
    logic [31:0]             hit_count_q, hit_count_d;
    logic [31:0]             miss_count_q, miss_count_d;

    logic [SET_BITS-1:0]     idx;
    logic [TAG_W-1:0]        tag_in;
    logic [1:0]              byte_off;
    logic                    hit;
    logic [DATA_WIDTH-1:0]   line;
    logic [DATA_WIDTH-1:0]   line_b, line_h, load_ext;
    logic [3:0]              st_strb;
    logic [DATA_WIDTH-1:0]   st_data, merged;
    logic                    line_we;
    logic [DATA_WIDTH-1:0]   line_wdata;

    assign idx      = aluresultm[SET_BITS+1:2];
    assign tag_in   = aluresultm[DATA_WIDTH-1:SET_BITS+2];
    assign byte_off = aluresultm[1:0];
    assign line     = data_q[idx];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag_in);

    assign line_b = line >> {byte_off, 3'b000};
    assign line_h = line >> {aluresultm[1], 4'b0000};

    always_comb begin
        case (funct3m)
            3'b000:  load_ext = {{(DATA_WIDTH-8){line_b[7]}}, line_b[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){line_h[15]}}, line_h[15:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, line_b[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, line_h[15:0]};
            default: load_ext = line;
        endcase
    end

    // Store data is moved onto its byte lanes so memory and the cache line see the same layout.
    always_comb begin
        case (funct3m[1:0])
            2'b00: begin
                st_strb = 4'b0001 << byte_off;
                st_data = {{(DATA_WIDTH-8){1'b0}}, writedatam[7:0]} << {byte_off, 3'b000};
            end
            2'b01: begin
                st_strb = 4'b0011 << {aluresultm[1], 1'b0};
                st_data = {{(DATA_WIDTH-16){1'b0}}, writedatam[15:0]} << {aluresultm[1], 4'b0000};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = writedatam;
            end
        endcase
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_merge
        assign merged[8*gi +: 8] = st_strb[gi % 4] ? st_data[8*gi +: 8] : line[8*gi +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Tag and data need no reset; the rst gate keeps an aborted access from landing.
    always_ff @(posedge clk) begin
        if (line_we && !rst) begin
            data_q[idx] <= line_wdata;
            tag_q[idx]  <= tag_in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (memwritem)
                    state_d = WRITE;
                else if (memreadm && !hit)
                    state_d = REFILL;
            end
            REFILL:  if (mem_ack) state_d = IDLE;
            WRITE:   if (mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        readdatam    = '0;
        stallm       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = 4'b0000;
        line_we      = 1'b0;
        line_wdata   = mem_rdata;
        valid_d      = valid_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        case (state_q)
            IDLE: begin
                if (memwritem) begin
                    stallm = 1'b1;
                end else if (memreadm) begin
                    if (hit) begin
                        readdatam   = load_ext;
                        hit_count_d = (hit_count_q == '1) ? hit_count_q : hit_count_q + 32'd1;
                    end else begin
                        stallm       = 1'b1;
                        miss_count_d = (miss_count_q == '1) ? miss_count_q : miss_count_q + 32'd1;
                    end
                end
            end
            REFILL: begin
                stallm   = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {aluresultm[DATA_WIDTH-1:2], 2'b00};
                if (mem_ack) begin
                    line_we      = 1'b1;
                    valid_d[idx] = 1'b1;
                end
            end
            WRITE: begin
                stallm     = 1'b1;
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = {aluresultm[DATA_WIDTH-1:2], 2'b00};
                mem_wdata  = st_data;
                mem_wstrb  = st_strb;
                line_wdata = merged;
                line_we    = mem_ack && hit;
            end
            default: ;
        endcase
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
endmodule

// File: tb/tb_mem_stage_cache.sv
// Directed-vector bench for mem_stage_cache: refill, load extension, store lanes, no-allocate,
// conflict eviction and reset abort, with hand-computed expectations.
module tb_mem_stage_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        memreadm, memwritem;
    logic [2:0]  funct3m;
    logic [31:0] aluresultm, writedatam, readdatam;
    logic        stallm, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    mem_stage_cache #(.DATA_WIDTH(32), .SET_BITS(3)) dut (
        .clk(clk), .rst(rst),
        .memreadm(memreadm), .memwritem(memwritem), .funct3m(funct3m),
        .aluresultm(aluresultm), .writedatam(writedatam),
        .readdatam(readdatam), .stallm(stallm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        memreadm  = 1'b0;
        memwritem = 1'b0;
        funct3m   = 3'b010;
        aluresultm = 32'h0;
        writedatam = 32'h0;
    endtask

    // Pulse mem_ack with the given read word for one cycle.
    task automatic ack_cycle(input logic [31:0] rdata);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        tick();
        tick();
        checks++; if (stallm !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stallm); end
        checks++; if ({mem_req, mem_we, mem_wstrb} !== 6'b0) begin errors++; $display("FAIL reset_mem got %b want 000000", {mem_req, mem_we, mem_wstrb}); end
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", hit_count, miss_count); end
        checks++; if (readdatam !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", readdatam); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_miss_refill;
        memreadm = 1'b1; funct3m = 3'b010; aluresultm = 32'h100;
        #1;
        checks++; if (stallm !== 1'b1) begin errors++; $display("FAIL miss_stall_now got %0b want 1", stallm); end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin errors++; $display("FAIL refill_req got req=%0b we=%0b addr=%h want 1 0 00000100", mem_req, mem_we, mem_addr); end
        checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL refill_miss_count got %0d want 1", miss_count); end
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (stallm !== 1'b1) begin errors++; $display("FAIL refill_ack_stall got %0b want 1", stallm); end
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        checks++; if (readdatam !== 32'hDEADBEEF || stallm !== 1'b0) begin errors++; $display("FAIL refill_hit got %h stall=%0b want deadbeef 0", readdatam, stallm); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL refill_hit_noreq got %0b want 0", mem_req); end
        tick();
        checks++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin errors++; $display("FAIL refill_counts got %0d/%0d want 1/1", hit_count, miss_count); end
        idle_inputs();
    endtask

    task automatic test_load_extend;
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adr [4] = '{32'h103, 32'h103, 32'h102, 32'h101};
        logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        for (int i = 0; i < 4; i++) begin
            memreadm = 1'b1; funct3m = f3[i]; aluresultm = adr[i];
            #1;
            checks++; if (readdatam !== exp[i] || stallm !== 1'b0) begin errors++; $display("FAIL load_ext_%0d got %h stall=%0b want %h 0", i, readdatam, stallm, exp[i]); end
            tick();
        end
        idle_inputs();
        #1;
        checks++; if (hit_count !== 32'd5) begin errors++; $display("FAIL load_ext_hits got %0d want 5", hit_count); end
        checks++; if (readdatam !== 32'h0 || mem_req !== 1'b0) begin errors++; $display("FAIL idle_outputs got rdata=%h req=%0b want 0 0", readdatam, mem_req); end
    endtask

    task automatic test_store_hit;
        memwritem = 1'b1; funct3m = 3'b000; aluresultm = 32'h101; writedatam = 32'h55;
        #1;
        checks++; if (stallm !== 1'b1) begin errors++; $display("FAIL sb_stall got %0b want 1", stallm); end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL sb_req got req=%0b we=%0b addr=%h want 1 1 00000100", mem_req, mem_we, mem_addr); end
        checks++; if (mem_wstrb !== 4'b0010 || mem_wdata !== 32'h00005500) begin errors++; $display("FAIL sb_lane got strb=%b data=%h want 0010 00005500", mem_wstrb, mem_wdata); end
        tick();
        ack_cycle(32'h0);
        idle_inputs();
        #1;
        checks++; if (stallm !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL sb_done got stall=%0b req=%0b want 0 0", stallm, mem_req); end
        memreadm = 1'b1; funct3m = 3'b010; aluresultm = 32'h100;
        #1;
        checks++; if (readdatam !== 32'hDEAD55EF || mem_req !== 1'b0 || stallm !== 1'b0) begin errors++; $display("FAIL sb_readback got %h req=%0b stall=%0b want dead55ef 0 0", readdatam, mem_req, stallm); end
        tick();
        idle_inputs();
        checks++; if (hit_count !== 32'd6 || miss_count !== 32'd1) begin errors++; $display("FAIL sb_counts got %0d/%0d want 6/1", hit_count, miss_count); end
    endtask

    task automatic test_store_miss_no_allocate;
        memwritem = 1'b1; funct3m = 3'b010; aluresultm = 32'h200; writedatam = 32'h12345678;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_wstrb !== 4'b1111 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h200) begin errors++; $display("FAIL sw_miss_req got we=%0b strb=%b data=%h addr=%h want 1 1111 12345678 00000200", mem_we, mem_wstrb, mem_wdata, mem_addr); end
        ack_cycle(32'h0);
        idle_inputs();
        memreadm = 1'b1; funct3m = 3'b010; aluresultm = 32'h200;
        #1;
        checks++; if (stallm !== 1'b1) begin errors++; $display("FAIL no_allocate got stall=%0b want 1", stallm); end
        tick();
        checks++; if (miss_count !== 32'd2) begin errors++; $display("FAIL no_allocate_miss got %0d want 2", miss_count); end
        ack_cycle(32'h12345678);
        #1;
        checks++; if (readdatam !== 32'h12345678) begin errors++; $display("FAIL sw_refill_data got %h want 12345678", readdatam); end
        tick();
        idle_inputs();
    endtask

    task automatic test_conflict;
        logic [31:0] adr [3] = '{32'h100, 32'h120, 32'h100};
        logic [31:0] dat [3] = '{32'h11110100, 32'hBBBB0120, 32'hAAAA0100};
        for (int i = 0; i < 3; i++) begin
            memreadm = 1'b1; funct3m = 3'b010; aluresultm = adr[i];
            #1;
            checks++; if (stallm !== 1'b1) begin errors++; $display("FAIL conflict_miss_%0d got stall=%0b want 1", i, stallm); end
            tick();
            checks++; if (mem_addr !== adr[i]) begin errors++; $display("FAIL conflict_addr_%0d got %h want %h", i, mem_addr, adr[i]); end
            ack_cycle(dat[i]);
            #1;
            checks++; if (readdatam !== dat[i]) begin errors++; $display("FAIL conflict_data_%0d got %h want %h", i, readdatam, dat[i]); end
            tick();
        end
        idle_inputs();
        checks++; if (hit_count !== 32'd10 || miss_count !== 32'd5) begin errors++; $display("FAIL conflict_counts got %0d/%0d want 10/5", hit_count, miss_count); end
    endtask

    task automatic test_both_high_half_store;
        memreadm = 1'b1; memwritem = 1'b1; funct3m = 3'b001; aluresultm = 32'h103; writedatam = 32'hFFFFABCD;
        #1;
        checks++; if (stallm !== 1'b1 || readdatam !== 32'h0) begin errors++; $display("FAIL both_idle got stall=%0b rdata=%h want 1 0", stallm, readdatam); end
        tick();
        checks++; if (mem_we !== 1'b1 || mem_wstrb !== 4'b1100 || mem_wdata !== 32'hABCD0000) begin errors++; $display("FAIL both_sh got we=%0b strb=%b data=%h want 1 1100 abcd0000", mem_we, mem_wstrb, mem_wdata); end
        ack_cycle(32'h0);
        idle_inputs();
        memreadm = 1'b1; funct3m = 3'b010; aluresultm = 32'h100;
        #1;
        checks++; if (readdatam !== 32'hABCD0100 || stallm !== 1'b0) begin errors++; $display("FAIL sh_readback got %h stall=%0b want abcd0100 0", readdatam, stallm); end
        tick();
        idle_inputs();
        checks++; if (hit_count !== 32'd11 || miss_count !== 32'd5) begin errors++; $display("FAIL both_counts got %0d/%0d want 11/5", hit_count, miss_count); end
    endtask

    task automatic test_reset_mid_refill;
        memreadm = 1'b1; funct3m = 3'b010; aluresultm = 32'h140;
        tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_refill_req got %0b want 1", mem_req); end
        rst = 1'b1;
        idle_inputs();
        #1;
        checks++; if (mem_req !== 1'b0 || stallm !== 1'b0 || miss_count !== 32'd0 || hit_count !== 32'd0) begin errors++; $display("FAIL abort_async got req=%0b stall=%0b cnt=%0d/%0d want 0 0 0/0", mem_req, stallm, hit_count, miss_count); end
        tick();
        rst = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        checks++; if (mem_req !== 1'b0 || stallm !== 1'b0 || readdatam !== 32'h0) begin errors++; $display("FAIL stale_ack got req=%0b stall=%0b rdata=%h want 0 0 0", mem_req, stallm, readdatam); end
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0 || mem_req !== 1'b0) begin errors++; $display("FAIL stale_ack_after got cnt=%0d/%0d req=%0b want 0/0 0", hit_count, miss_count, mem_req); end
        memreadm = 1'b1; funct3m = 3'b010; aluresultm = 32'h100;
        #1;
        checks++; if (stallm !== 1'b1 || readdatam !== 32'h0) begin errors++; $display("FAIL valid_cleared got stall=%0b rdata=%h want 1 0", stallm, readdatam); end
        aluresultm = 32'h140;
        #1;
        checks++; if (stallm !== 1'b1) begin errors++; $display("FAIL aborted_line_invalid got stall=%0b want 1", stallm); end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_load_miss_refill();
        test_load_extend();
        test_store_hit();
        test_store_miss_no_allocate();
        test_conflict();
        test_both_high_half_store();
        test_reset_mid_refill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_cache.md
MEM_STAGE_CACHE -- requirements
Module: mem_stage_cache

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data and address width.
REQ-002 SHALL have parameter SET_BITS, default 3: index width; 2**SET_BITS direct-mapped one-word lines; tag = address[DATA_WIDTH-1:SET_BITS+2].
REQ-003 SHALL have ports, clock and reset first, as follows:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- memreadm  in  1  load in memory stage.
- memwritem  in  1  store in memory stage.
- funct3m  in  3  access size/sign (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
- aluresultm  in  DATA_WIDTH  byte address.
- writedatam  in  DATA_WIDTH  store data, right-aligned.
- readdatam  out  DATA_WIDTH  extended load data, to the MEM/WB register.
- stallm  out  1  freeze request to the hazard unit.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_WIDTH  word-aligned address (bits [1:0] = 0).
- mem_wdata  out  DATA_WIDTH  lane-aligned store data.
- mem_wstrb  out  4  byte enables.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  DATA_WIDTH  read word, valid with mem_ack.
- hit_count, miss_count  out  32 each  saturating load hit/miss counters.

Function
REQ-004 SHALL implement FSM states IDLE, REFILL, WRITE; valid, tag and data arrays are registers.
REQ-005 IDLE, load, valid and tag match: SHALL drive readdatam combinationally in the same cycle with stallm=0, and increment hit_count at the clock edge.
REQ-006 IDLE, load miss: SHALL assert stallm combinationally, increment miss_count, and go to REFILL at the next edge.
REQ-007 REFILL: SHALL hold mem_req=1, mem_we=0 and mem_addr={addr[31:2],2'b00} until mem_ack. On mem_ack it SHALL write the line, set valid and tag, and return to IDLE. The retried load then hits, so minimum miss penalty is 2 cycles plus memory latency.
REQ-008 IDLE, store: SHALL assert stallm and go to WRITE (write-through, no-write-allocate).
REQ-009 WRITE: SHALL hold mem_req=1, mem_we=1, mem_wdata and mem_wstrb until mem_ack. On mem_ack it SHALL update the enabled bytes of the line if it is a hit, leave a miss line untouched, and return to IDLE with stallm=0 in IDLE.
REQ-010 Lanes:
- Byte: lane = addr[1:0].
- Half: lanes {addr[1],0},{addr[1],1}; addr[0] ignored.
- Word: all lanes; addr[1:0] ignored.
- Store strobes: 0001<<addr[1:0], 0011<<(2*addr[1]), 1111.
REQ-011 Load extension SHALL be:
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- LW and undefined funct3: full word.
REQ-012 stallm SHALL be 1 throughout REFILL and WRITE, including the mem_ack cycle. In IDLE it SHALL be 1 only for a miss or store.
REQ-013 memreadm and memwritem both high SHALL be treated as a store.
REQ-014 In IDLE, with no access, all mem_* outputs SHALL be 0 and readdatam SHALL be 0. mem_ack SHALL be ignored in IDLE.
REQ-015 hit_count and miss_count SHALL saturate at 32'hFFFF_FFFF. Stores SHALL count as neither.
REQ-016 Inputs SHALL be held stable by upstream while stallm=1; the block need not latch them.

Reset
REQ-017 rst SHALL force:
- state IDLE;
- all valid bits 0;
- counters 0;
- mem_req/mem_we/mem_wstrb 0;
- stallm 0.
Tag and data contents are don't-care.
REQ-018 rst asserted mid-REFILL or mid-WRITE SHALL abort the access without touching the arrays. A later mem_ack for the aborted request SHALL be ignored.

Verification
REQ-019 LW 0x100 after reset: stallm=1 immediately; mem_req=1, mem_addr=0x100; ack after 3 cycles with rdata 0xDEADBEEF; next cycle hit with readdatam=0xDEADBEEF, stallm=0; miss_count=1, hit_count=1.
REQ-020 Line 0x100 cached 0xDEADBEEF: LB 0x103 gives 0xFFFFFFDE; LBU 0x103 gives 0x000000DE; LH 0x102 gives 0xFFFFDEAD; LHU 0x101 gives 0x0000BEEF.
REQ-021 SB 0x101 data 0x55 on a hit: mem_wstrb=0010, mem_wdata=0x00005500; after ack, LW 0x100 hits with 0xDEAD55EF and no mem_req.
REQ-022 SW to miss address 0x200 with 0x12345678: a write occurs; the next LW 0x200 misses (no allocate); miss_count increments.
REQ-023 Conflict: LW 0x100, then LW 0x120 (SET_BITS=3, same index) evicts; LW 0x100 misses again.
REQ-024 rst pulsed during REFILL, stale mem_ack two cycles later: state stays IDLE, valid=0, readdatam=0, counters 0.
